// File: rtl/goe_mport_pkg.sv
// goe_pkg: shared constants for the N-port egress distributor.
//   DATA_W      width of one UDA packet word (2-bit header, 4-bit byte-valid, 128-bit data)
//   HDR_*       word-type codes carried in bits [133:132]
//   goe_state_e distributor state encoding
//   force_tail  rewrites a word's header to TAIL, leaving the payload untouched
package goe_pkg;

    localparam int DATA_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } goe_state_e;

    function automatic logic [DATA_W-1:0] force_tail(input logic [DATA_W-1:0] i_word);
        return {HDR_TAIL, i_word[DATA_W-3:0]};
    endfunction

endpackage

// File: rtl/goe_mport_if.sv
// goe_mport_if: groups the egress distributor's packet stream and stat counters.
//   in_goe_*        single input packet stream (word strobe, word, valid strobe, good flag)
//   pktout_*        NPORTS output channels, channel i data at [i*DATA_W +: DATA_W]
//   drop_cnt        packets dropped for an out-of-range outport
//   err_cnt         malformed-sequence events
//   master modport  packet source / stat reader; slave modport  the distributor
interface goe_mport_if #(
    parameter int NPORTS = 4,
    parameter int CNT_W  = 16
);
    logic                              in_goe_data_wr;
    logic [goe_pkg::DATA_W-1:0]        in_goe_data;
    logic                              in_goe_valid_wr;
    logic                              in_goe_valid;
    logic [NPORTS-1:0]                 pktout_data_wr;
    logic [NPORTS*goe_pkg::DATA_W-1:0] pktout_data;
    logic [NPORTS-1:0]                 pktout_data_valid_wr;
    logic [NPORTS-1:0]                 pktout_data_valid;
    logic [CNT_W-1:0]                  drop_cnt;
    logic [CNT_W-1:0]                  err_cnt;

    modport master (
        output in_goe_data_wr, in_goe_data, in_goe_valid_wr, in_goe_valid,
        input  pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid,
        input  drop_cnt, err_cnt
    );

    modport slave (
        input  in_goe_data_wr, in_goe_data, in_goe_valid_wr, in_goe_valid,
        output pktout_data_wr, pktout_data, pktout_data_valid_wr, pktout_data_valid,
        output drop_cnt, err_cnt
    );
endinterface

// File: rtl/goe_mport_sat_cnt.sv
// goe_sat_cnt: event counter that sticks at all-ones instead of wrapping.
//   clk      clock
//   rst_n    synchronous active-low reset, clears the count
//   i_inc    count one event this cycle
//   o_count  current count
module goe_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/goe_mport.sv
// goe_mport: steers each whole packet of the input stream to one of NPORTS output
// channels chosen by the outport field of its head word. Out-of-range packets are
// dropped whole; a head arriving before the previous tail closes the open packet
// as bad and drops the new one. All outputs registered, one cycle of latency.
//   clk    clock
//   rst_n  synchronous active-low reset
//   bus    goe_mport_if slave: input stream in, channel outputs and counters out
//
// state   | meaning
// IDLE    | between packets, waiting for a head word
// FWD     | packet open, words go to channel r_sel
// DROP    | discarding words until the next tail
module goe_mport
    import goe_pkg::*;
#(
    parameter int NPORTS   = 4,
    parameter int PORT_LSB = 112,
    parameter int PORT_W   = 6,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    goe_mport_if.slave   bus
);

    localparam int SEL_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    goe_state_e          r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt, w_chan;
    logic                w_emit, w_vwr, w_v, w_drop_inc, w_err_inc;
    logic [DATA_W-1:0]   w_word;
    logic [1:0]          w_hdr;
    logic [PORT_W-1:0]   w_port;
    logic                w_port_ok;

    logic [NPORTS-1:0]        r_wr, r_vwr, r_v;
    logic [NPORTS*DATA_W-1:0] r_data;

    assign w_hdr     = bus.in_goe_data[DATA_W-1 -: 2];
    assign w_port    = bus.in_goe_data[PORT_LSB +: PORT_W];
    // one extra bit so NPORTS = 2**PORT_W still compares correctly
    assign w_port_ok = ({1'b0, w_port} < (PORT_W+1)'(NPORTS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_chan      = r_sel;
        w_emit      = 1'b0;
        w_word      = bus.in_goe_data;
        w_vwr       = 1'b0;
        w_v         = 1'b0;
        w_drop_inc  = 1'b0;
        w_err_inc   = 1'b0;
        if (bus.in_goe_data_wr) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr == HDR_HEAD) begin
                        if (w_port_ok) begin
                            w_emit      = 1'b1;
                            w_chan      = w_port[SEL_W-1:0];
                            w_sel_nxt   = w_chan;
                            w_state_nxt = ST_FWD;
                        end else begin
                            w_drop_inc  = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                    end else begin
                        w_err_inc = 1'b1;
                    end
                end
                ST_FWD: begin
                    case (w_hdr)
                        HDR_BODY: w_emit = 1'b1;
                        HDR_TAIL: begin
                            w_emit      = 1'b1;
                            w_vwr       = bus.in_goe_valid_wr;
                            w_v         = bus.in_goe_valid_wr & bus.in_goe_valid;
                            w_state_nxt = ST_IDLE;
                        end
                        HDR_HEAD: begin
                            // close the open packet as bad using this word as its tail
                            w_emit      = 1'b1;
                            w_word      = force_tail(bus.in_goe_data);
                            w_vwr       = 1'b1;
                            w_err_inc   = 1'b1;
                            w_state_nxt = ST_DROP;
                        end
                        default: ;
                    endcase
                end
                ST_DROP: begin
                    if (w_hdr == HDR_HEAD) begin
                        w_err_inc = 1'b1;
                    end else if (w_hdr == HDR_TAIL) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        always_ff @(posedge clk) begin
            if (!rst_n || !(w_emit && (w_chan == SEL_W'(gi)))) begin
                r_wr[gi]                    <= 1'b0;
                r_data[gi*DATA_W +: DATA_W] <= '0;
                r_vwr[gi]                   <= 1'b0;
                r_v[gi]                     <= 1'b0;
            end else begin
                r_wr[gi]                    <= 1'b1;
                r_data[gi*DATA_W +: DATA_W] <= w_word;
                r_vwr[gi]                   <= w_vwr;
                r_v[gi]                     <= w_v;
            end
        end
    end

    assign bus.pktout_data_wr       = r_wr;
    assign bus.pktout_data          = r_data;
    assign bus.pktout_data_valid_wr = r_vwr;
    assign bus.pktout_data_valid    = r_v;

    goe_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_drop_inc),
        .o_count (bus.drop_cnt)
    );

    goe_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_err_inc),
        .o_count (bus.err_cnt)
    );

endmodule

// File: tb/tb_goe_mport.sv
// Bench for goe_mport: directed scenarios plus randomized packet traffic, checked
// every cycle against a packet-level model. A second instance with 2-bit counters
// sees the same stream so counter saturation is exercised too.
module tb_goe_mport;
    import goe_pkg::*;

    localparam int NP = 4;
    localparam int DW = DATA_W;
    localparam int CW = NP * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    initial forever #5 clk = ~clk;

    logic          s_wr = 1'b0, s_vwr = 1'b0, s_v = 1'b0;
    logic [DW-1:0] s_data = '0;

    goe_mport_if #(.NPORTS(NP), .CNT_W(16)) ifa ();
    goe_mport_if #(.NPORTS(NP), .CNT_W(2))  ifb ();

    assign ifa.in_goe_data_wr  = s_wr;
    assign ifa.in_goe_data     = s_data;
    assign ifa.in_goe_valid_wr = s_vwr;
    assign ifa.in_goe_valid    = s_v;
    assign ifb.in_goe_data_wr  = s_wr;
    assign ifb.in_goe_data     = s_data;
    assign ifb.in_goe_valid_wr = s_vwr;
    assign ifb.in_goe_valid    = s_v;

    goe_mport #(.NPORTS(NP), .PORT_LSB(112), .PORT_W(6), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    goe_mport #(.NPORTS(NP), .PORT_LSB(112), .PORT_W(6), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    // ---------------- packet-level model ----------------
    // cur: -1 between packets, -2 discarding a packet, >=0 channel of the open packet
    logic [NP-1:0] e_wr, e_vwr, e_v;
    logic [CW-1:0] e_data;
    int cur = -1;
    int mdrop = 0;
    int merr = 0;
    bit started = 1'b0;

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    task automatic m_emit(input int ch, input logic [DW-1:0] w, input logic vw, input logic vv);
        e_wr[ch]             = 1'b1;
        e_data[ch*DW +: DW]  = w;
        e_vwr[ch]            = vw;
        e_v[ch]              = vv;
    endtask

    always @(posedge clk) begin
        logic [1:0] hdr;
        int p;
        started = 1'b1;
        e_wr = '0; e_vwr = '0; e_v = '0; e_data = '0;
        hdr = s_data[DW-1 -: 2];
        p = int'(s_data[112 +: 6]);
        if (!rst_n) begin
            cur = -1; mdrop = 0; merr = 0;
        end else if (s_wr) begin
            if (cur == -1) begin
                if (hdr == 2'b01) begin
                    if (p < NP) begin m_emit(p, s_data, 1'b0, 1'b0); cur = p; end
                    else begin mdrop++; cur = -2; end
                end else merr++;
            end else if (cur >= 0) begin
                if (hdr == 2'b11) m_emit(cur, s_data, 1'b0, 1'b0);
                else if (hdr == 2'b10) begin
                    m_emit(cur, s_data, s_vwr, s_vwr & s_v);
                    cur = -1;
                end else if (hdr == 2'b01) begin
                    m_emit(cur, {2'b10, s_data[DW-3:0]}, 1'b1, 1'b0);
                    merr++;
                    cur = -2;
                end
            end else begin
                if (hdr == 2'b10) cur = -1;
                else if (hdr == 2'b01) merr++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a_wr",    CW'(ifa.pktout_data_wr),       CW'(e_wr));
            chk("a_data",  ifa.pktout_data,               e_data);
            chk("a_vwr",   CW'(ifa.pktout_data_valid_wr), CW'(e_vwr));
            chk("a_valid", CW'(ifa.pktout_data_valid),    CW'(e_v));
            chk("a_drop",  CW'(ifa.drop_cnt),             CW'(sat(mdrop, 65535)));
            chk("a_err",   CW'(ifa.err_cnt),              CW'(sat(merr, 65535)));
            chk("b_data",  ifb.pktout_data,               e_data);
            chk("b_drop",  CW'(ifb.drop_cnt),             CW'(sat(mdrop, 3)));
            chk("b_err",   CW'(ifb.err_cnt),              CW'(sat(merr, 3)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wr, input logic [DW-1:0] d, input logic vw, input logic vv);
        @(posedge clk);
        #1;
        s_wr = wr; s_data = d; s_vwr = vw; s_v = vv;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] hdr, input int port);
        logic [DW-1:0] w;
        w[31:0]    = $urandom;
        w[63:32]   = $urandom;
        w[95:64]   = $urandom;
        w[127:96]  = $urandom;
        w[131:128] = 4'($urandom);
        w[133:132] = hdr;
        if (port >= 0) w[117:112] = 6'(port);
        return w;
    endfunction

    task automatic send_pkt(input int port, input int nw, input logic good);
        drive(1'b1, mk(HDR_HEAD, port), 1'b0, 1'b0);
        for (int i = 0; i < nw - 2; i++) drive(1'b1, mk(HDR_BODY, -1), 1'($urandom), 1'b1);
        drive(1'b1, mk(HDR_TAIL, -1), 1'b1, good);
    endtask

    initial begin
        // reset
        idle(3);
        chk("rst_wr", CW'(ifa.pktout_data_wr), '0);
        chk("rst_cnt", CW'({ifa.drop_cnt, ifa.err_cnt}), '0);
        rst_n = 1'b1;
        idle(2);

        // 3-word packet to port 2
        drive(1'b1, mk(HDR_HEAD, 2), 1'b0, 1'b0);
        drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
        chk("t1_head_on_ch2", CW'(ifa.pktout_data_wr), CW'(4'b0100));
        drive(1'b1, mk(HDR_TAIL, -1), 1'b1, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t1_tail_valid", CW'({ifa.pktout_data_valid_wr, ifa.pktout_data_valid}), CW'(8'b0100_0100));
        idle(2);

        // back-to-back to ports 0 and 3
        send_pkt(0, 3, 1'b1);
        send_pkt(3, 2, 1'b0);
        idle(2);

        // out-of-range outport, then a normal packet
        send_pkt(5, 4, 1'b1);
        idle(2);
        chk("t3_drop_cnt", CW'(ifa.drop_cnt), CW'(16'd1));
        send_pkt(1, 3, 1'b1);
        idle(2);

        // head before tail
        drive(1'b1, mk(HDR_HEAD, 1), 1'b0, 1'b0);
        drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
        drive(1'b1, mk(HDR_HEAD, 0), 1'b0, 1'b0);
        drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
        chk("t4_forced_tail", CW'({ifa.pktout_data_valid_wr, ifa.pktout_data_valid}), CW'(8'b0010_0000));
        chk("t4_forced_hdr", CW'(ifa.pktout_data[DW + 132 +: 2]), CW'(2'b10));
        drive(1'b1, mk(HDR_TAIL, -1), 1'b1, 1'b1);
        idle(2);
        chk("t4_err_cnt", CW'(ifa.err_cnt), CW'(16'd1));

        // wr gaps, then reset mid-packet
        drive(1'b1, mk(HDR_HEAD, 3), 1'b0, 1'b0);
        idle(3);
        drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("t5_rst_out", CW'(ifa.pktout_data_wr), '0);
        drive(1'b1, mk(HDR_TAIL, -1), 1'b1, 1'b1);
        idle(2);
        chk("t5_err_after_rst", CW'(ifa.err_cnt), CW'(16'd2));

        // saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) send_pkt(4 + i, 2, 1'b1);
        idle(2);
        chk("t6_drop_a", CW'(ifa.drop_cnt), CW'(16'd5));
        chk("t6_drop_b_sat", CW'(ifb.drop_cnt), CW'(2'd3));

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                drive(1'b1, mk(($urandom_range(0, 1) != 0) ? HDR_BODY : HDR_TAIL, -1), 1'b1, 1'b1);
            end else if (r < 6) begin
                drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
            end else begin
                int port, nw;
                port = (r < 9) ? 63 : int'($urandom_range(0, 7));
                nw = int'($urandom_range(2, 5));
                drive(1'b1, mk(HDR_HEAD, port), 1'b0, 1'b0);
                for (int k = 0; k < nw - 2; k++) begin
                    if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
                    drive(1'b1, mk(HDR_BODY, -1), 1'($urandom), 1'($urandom));
                end
                if ($urandom_range(0, 11) == 0) begin
                    drive(1'b1, mk(HDR_HEAD, int'($urandom_range(0, 7))), 1'b0, 1'b0);
                    drive(1'b1, mk(HDR_BODY, -1), 1'b0, 1'b0);
                end
                drive(1'b1, mk(HDR_TAIL, -1), 1'($urandom_range(0, 7) != 0), 1'($urandom));
                if ($urandom_range(0, 3) == 0) idle(1);
            end
        end
        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
